// File: rtl/mult_div_unit.sv
// Iterative HI/LO multiply/divide unit: radix-2 shift-add multiply and restoring divide,
// 32 iteration cycles plus one sign-fixup cycle. Holds the architectural HI and LO registers.
module mult_div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] rs_val_i,
  input  logic [WIDTH-1:0] rt_val_i,
  input  logic             mthi_i,
  input  logic             mtlo_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

  state_e                 state_q, state_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic                   busy_q, busy_d, done_q, done_d;
  logic [WIDTH-1:0]       hi_q, hi_d, lo_q, lo_d;
  logic [2*WIDTH-1:0]     acc_q, acc_d;
  logic [WIDTH-1:0]       opd_q, opd_d, rs_raw_q, rs_raw_d;
  logic                   is_div_q, is_div_d, neg_q, neg_d, rem_neg_q, rem_neg_d;

  logic [WIDTH-1:0]       rs_mag, rt_mag;
  logic                   signed_op;
  logic [WIDTH:0]         mul_sum, div_shl, div_diff;
  logic                   div_ge;
  logic [2*WIDTH-1:0]     mul_next, div_next, prod;
  logic [WIDTH-1:0]       quot_fix, rem_fix;

  // op[1] selects divide, op[0] selects unsigned
  assign signed_op = ~op_i[0];
  assign rs_mag    = (signed_op && rs_val_i[WIDTH-1]) ? -rs_val_i : rs_val_i;
  assign rt_mag    = (signed_op && rt_val_i[WIDTH-1]) ? -rt_val_i : rt_val_i;

  // Multiply: accumulator holds {partial product, remaining multiplier bits}
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opd_q} : '0);
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

  // Divide: accumulator holds {partial remainder, dividend bits shifting into quotient}
  assign div_shl  = acc_q[2*WIDTH-1:WIDTH-1];
  assign div_ge   = div_shl >= {1'b0, opd_q};
  assign div_diff = div_shl - {1'b0, opd_q};
  assign div_next = {(div_ge ? div_diff[WIDTH-1:0] : div_shl[WIDTH-1:0]),
                     acc_q[WIDTH-2:0], div_ge};

  assign prod     = neg_q ? -acc_q : acc_q;
  assign quot_fix = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rem_fix  = rem_neg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      acc_q     <= '0;
      opd_q     <= '0;
      rs_raw_q  <= '0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      acc_q     <= acc_d;
      opd_q     <= opd_d;
      rs_raw_q  <= rs_raw_d;
      is_div_q  <= is_div_d;
      neg_q     <= neg_d;
      rem_neg_q <= rem_neg_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start_i) state_d = StCalc;
      StCalc:  if (cnt_q == CntLast) state_d = StFix;
      StFix:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    acc_d     = acc_q;
    opd_d     = opd_q;
    rs_raw_d  = rs_raw_q;
    is_div_d  = is_div_q;
    neg_d     = neg_q;
    rem_neg_d = rem_neg_q;
    busy_d    = (state_d != StIdle);
    done_d    = (state_q == StFix);
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          cnt_d     = '0;
          is_div_d  = op_i[1];
          rs_raw_d  = rs_val_i;
          neg_d     = signed_op && (rs_val_i[WIDTH-1] ^ rt_val_i[WIDTH-1]);
          rem_neg_d = signed_op && op_i[1] && rs_val_i[WIDTH-1];
          opd_d     = op_i[1] ? rt_mag : rs_mag;
          acc_d     = {{WIDTH{1'b0}}, (op_i[1] ? rs_mag : rt_mag)};
        end else begin
          if (mthi_i) hi_d = rs_val_i;
          if (mtlo_i) lo_d = rs_val_i;
        end
      end
      StCalc: begin
        cnt_d = cnt_q + 1'b1;
        acc_d = is_div_q ? div_next : mul_next;
      end
      StFix: begin
        if (!is_div_q) begin
          hi_d = prod[2*WIDTH-1:WIDTH];
          lo_d = prod[WIDTH-1:0];
        end else if (opd_q == '0) begin
          hi_d = rs_raw_q;
          lo_d = '1;
        end else begin
          hi_d = rem_fix;
          lo_d = quot_fix;
        end
      end
      default: ;
    endcase
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: table of directed ops plus hand-written
// sequences for start/mthi filtering and mid-operation reset.
module tb_mult_div_unit;

  logic        clk, rst_n, start, mthi, mtlo;
  logic [1:0]  op;
  logic [31:0] rs_val, rt_val, hi, lo;
  logic        busy, done;

  int n_checks = 0;
  int n_fail   = 0;

  mult_div_unit #(.WIDTH(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (start),
    .op_i     (op),
    .rs_val_i (rs_val),
    .rt_val_i (rt_val),
    .mthi_i   (mthi),
    .mtlo_i   (mtlo),
    .busy_o   (busy),
    .done_o   (done),
    .hi_o     (hi),
    .lo_o     (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Called #1 after a rising edge; returns cycles until done and cycles with busy high.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output int bcnt);
    start  = 1'b1;
    op     = o;
    rs_val = a;
    rt_val = b;
    @(posedge clk); #1;
    start = 1'b0;
    lat   = 0;
    bcnt  = busy ? 1 : 0;
    while (!done && lat < 50) begin
      @(posedge clk); #1;
      lat++;
      if (busy) bcnt++;
    end
  endtask

  initial begin
    int lat, bcnt, seen;

    vecs[0] = '{"mult_neg3x7",    2'b00, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB};
    vecs[1] = '{"multu_max",      2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[2] = '{"mult_minxmin",   2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    vecs[3] = '{"div_neg7by2",    2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[4] = '{"div_7byneg2",    2'b10, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
    vecs[5] = '{"div_overflow",   2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vecs[6] = '{"divu_by0",       2'b11, 32'h00000064, 32'h00000000, 32'h00000064, 32'hFFFFFFFF};
    vecs[7] = '{"div_neg_by0",    2'b10, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF};
    vecs[8] = '{"divu_max_by3",   2'b11, 32'hFFFFFFFF, 32'h00000003, 32'h00000000, 32'h55555555};
    vecs[9] = '{"multu_wide",     2'b01, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780};

    rst_n = 1'b0; start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    op = 2'b00; rs_val = '0; rt_val = '0;
    #1;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_hi", hi, 32'd0);
    chk("reset_lo", lo, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].op, vecs[i].rs, vecs[i].rt, lat, bcnt);
      chk({vecs[i].name, "_latency"}, 32'(lat), 32'd33);
      chk({vecs[i].name, "_busy_cycles"}, 32'(bcnt), 32'd33);
      chk({vecs[i].name, "_hi"}, hi, vecs[i].exp_hi);
      chk({vecs[i].name, "_lo"}, lo, vecs[i].exp_lo);
      @(posedge clk); #1;
      chk({vecs[i].name, "_done_pulse"}, 32'(done), 32'd0);
    end

    // start and mthi during a MULTU 6*7 in flight are ignored
    start = 1'b1; op = 2'b01; rs_val = 32'd6; rt_val = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    start = 1'b1; op = 2'b11; rs_val = 32'h1234; rt_val = 32'd4; mthi = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; mthi = 1'b0;
    chk("filter_busy_mid", 32'(busy), 32'd1);
    chk("filter_hi_mid", hi, 32'h00000001);
    lat = 0;
    while (!done && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("filter_total_latency", 32'(lat + 11), 32'd33);
    chk("filter_hi", hi, 32'd0);
    chk("filter_lo", lo, 32'd42);
    @(posedge clk); #1;
    chk("filter_no_restart", 32'(busy), 32'd0);

    mtlo = 1'b1; rs_val = 32'hABCD;
    @(posedge clk); #1;
    mtlo = 1'b0;
    chk("mtlo_lo", lo, 32'h0000ABCD);
    chk("mtlo_hi_kept", hi, 32'd0);

    // start wins over a simultaneous mthi
    mthi = 1'b1; start = 1'b1; op = 2'b01; rs_val = 32'd3; rt_val = 32'd3;
    @(posedge clk); #1;
    mthi = 1'b0; start = 1'b0;
    chk("start_wins_hi", hi, 32'd0);
    chk("start_wins_busy", 32'(busy), 32'd1);
    lat = 0;
    while (!done && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("start_wins_lo", lo, 32'd9);
    @(posedge clk); #1;

    mthi = 1'b1; mtlo = 1'b1; rs_val = 32'h5A5A0001;
    @(posedge clk); #1;
    mthi = 1'b0; mtlo = 1'b0;
    chk("mt_both_hi", hi, 32'h5A5A0001);
    chk("mt_both_lo", lo, 32'h5A5A0001);

    // reset mid-operation aborts without a result or done pulse
    start = 1'b1; op = 2'b00; rs_val = 32'd5; rt_val = 32'd5;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (19) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_hi", hi, 32'd0);
    chk("abort_lo", lo, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (done || busy) seen++;
    end
    chk("abort_no_done", 32'(seen), 32'd0);

    run_op(2'b00, 32'd5, 32'd5, lat, bcnt);
    chk("after_reset_latency", 32'(lat), 32'd33);
    chk("after_reset_hi", hi, 32'd0);
    chk("after_reset_lo", lo, 32'd25);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
